kaipokrandt_mem_ctrl: RTL
=========================

# kaipokrandt_mem_ctrl

Memory access controller that shares the single memory port, and the memory address register in front of it, between two requesters: instruction fetch (read-only) and data (read/write). For each access it grants one requester, loads its address into the MAR, drives the memory strobe for a fixed latency, captures read data and returns a one-cycle acknowledge. It sits between the control unit's fetch/execute logic and the MAR/memory pair.

## Interface
- `MEM_LAT`, 2: memory access cycles per transfer, legal range 1..15.
- `clk` input 1: system clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `f_req` input 1: fetch request, held until `f_ack`.
- `f_addr` input 16: fetch address, stable while `f_req`.
- `f_ack` output 1: one-cycle fetch completion; `rdata` valid in the same cycle.
- `d_req` input 1: data request, held until `d_ack`.
- `d_we` input 1: 1 = write, 0 = read; stable while `d_req`.
- `d_addr` input 16: data address.
- `d_wdata` input 16: write data.
- `d_ack` output 1: one-cycle data completion.
- `rdata` output 16: last captured read data, held until the next read capture.
- `mar_load` output 1: MAR load strobe.
- `mar_bus` output 16: address presented to the MAR bus input.
- `mem_rd` output 1: memory read strobe.
- `mem_wr` output 1: memory write strobe.
- `mem_wdata` output 16: write data to memory.
- `mem_rdata` input 16: memory read data, valid on the last access cycle.
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD, ACCESS, DONE. Registers: state, `grant` (0 = fetch, 1 = data), `cnt` (4 bits), `rdata`, `last`.
- IDLE: if any request is pending, latch `grant` by the arbitration rule and go to LOAD; otherwise stay.
- LOAD: `mar_load`=1 and `mar_bus` = granted address. Next state is ACCESS with `cnt`=0.
- ACCESS: `mar_bus` holds the granted address.
  - `mem_rd`=1 for a fetch or a data read; `mem_wr`=1 for a data write.
  - `mem_wdata` = `d_wdata` whenever `grant`=data, else 0.
  - `cnt` increments each cycle. When `cnt`==MEM_LAT-1, go to DONE; on that edge, for a read, `rdata` <= `mem_rdata`.
- DONE: assert `f_ack` or `d_ack` according to `grant`, then return to IDLE.
  - Only one ack is asserted at a time, and both acks are 0 in every other state.
  - A write leaves `rdata` unchanged.
- Outside LOAD and ACCESS, `mar_bus` is 0 and all strobes are 0. Outputs are decoded from registered state.
- A request dropped mid-transfer does not abort the transfer; it still completes and acks.
- `d_we` is sampled at the IDLE→LOAD edge.

## Timing
- Reset (asynchronous, any state) forces:
  - state IDLE, `cnt` 0, `rdata` 0x0000, `last` = data;
  - all strobes, acks, `busy` and `mar_bus` to 0.
- Reset mid-transfer aborts the transfer with no ack.
- Latency: a request sampled in IDLE at edge k produces:
  - LOAD in cycle k+1;
  - ACCESS in cycles k+2 .. k+1+MEM_LAT;
  - ack in cycle k+2+MEM_LAT.
- Throughput: the request is sampled again in IDLE on the cycle after DONE, so back-to-back accesses take MEM_LAT+3 cycles each.
- A requester must deassert `req` in the cycle after its ack, or the request is served again.

## Configuration
- `MEMCTRL_RR_EN` defined: round-robin arbitration.
  - When both requests are pending, grant the requester not in `last`.
  - `last` is updated on every grant.
  - Reset value of `last` = data, so fetch wins the first conflict.
- `MEMCTRL_RR_EN` undefined: fixed priority, fetch always wins. `last` is not implemented and data may starve.

## Test plan
- Reset: assert `reset` mid-ACCESS → same cycle all outputs 0 and `rdata`=0x0000; after release, idle with `busy`=0.
- Single fetch, MEM_LAT=2: `f_req`, `f_addr`=0x1234, `mem_rdata`=0xBEEF on the last access cycle → `mar_load` with `mar_bus`=0x1234 one cycle after the request is sampled, `mem_rd` high 2 cycles, `f_ack` high exactly one cycle at k+4 with `rdata`=0xBEEF.
- Data write: `d_we`=1, `d_addr`=0x00FF, `d_wdata`=0xA5A5 → `mem_wr` high MEM_LAT cycles with `mem_wdata`=0xA5A5, `d_ack` one cycle, `rdata` unchanged.
- Conflict: `f_req` and `d_req` asserted together and held across three grants.
  - With `MEMCTRL_RR_EN`: grant order fetch, data, fetch.
  - Without it: three fetch grants and no `d_ack`.
- Latency sweep with MEM_LAT=1 and MEM_LAT=15: ack arrives exactly MEM_LAT+2 cycles after the sampling edge, and `cnt` wrap does not corrupt the next transfer.
- Dropped request: deassert `d_req` during ACCESS → the transfer completes and `d_ack` still pulses once.

Source files
------------

// File: rtl/kaipokrandt_mem_ctrl.sv
// Shared memory port controller: arbitrates fetch and data requesters onto one MAR/memory pair.
// Define MEMCTRL_RR_EN for round-robin arbitration; otherwise fetch has fixed priority.
module kaipokrandt_mem_ctrl #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] rdata,
  output logic        mar_load,
  output logic [15:0] mar_bus,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StAccess, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;  // 0 = fetch, 1 = data
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        grant_sel;

`ifdef MEMCTRL_RR_EN
  logic last_q, last_d;

  // On a conflict the requester that was not granted last time wins.
  always_comb begin
    grant_sel = (f_req && d_req) ? ~last_q : d_req;
  end
`else
  always_comb begin
    grant_sel = ~f_req;
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef MEMCTRL_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      StIdle: begin
        if (f_req || d_req) begin
          grant_d = grant_sel;
          we_d    = grant_sel & d_we;
`ifdef MEMCTRL_RR_EN
          last_d  = grant_sel;
`endif
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = 4'd0;
        state_d = StAccess;
      end
      StAccess: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          if (!(grant_q && we_q)) begin
            rdata_d = mem_rdata;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
      rdata_q <= 16'h0000;
`ifdef MEMCTRL_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef MEMCTRL_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  logic in_load, in_access, in_done;

  always_comb begin
    in_load   = (state_q == StLoad);
    in_access = (state_q == StAccess);
    in_done   = (state_q == StDone);
    mar_load  = in_load;
    mar_bus   = (in_load || in_access) ? (grant_q ? d_addr : f_addr) : 16'h0000;
    mem_rd    = in_access && !(grant_q && we_q);
    mem_wr    = in_access && grant_q && we_q;
    mem_wdata = grant_q ? d_wdata : 16'h0000;
    f_ack     = in_done && !grant_q;
    d_ack     = in_done && grant_q;
    busy      = (state_q != StIdle);
    rdata     = rdata_q;
  end

endmodule
